// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for a shared combinational ALU. One operation is
//   in flight at a time: IDLE grants and latches operands, EXEC holds them on
//   the ALU for ALU_LAT cycles, RESP presents the captured result until the
//   consumer takes it. Ties go to the requester not served last.
// Ports
//   clock, reset                 : clock, synchronous active-high reset
//   reqN_valid/ready             : per-requester handshake (ready is combinational)
//   reqN_instr/a/b               : per-requester instruction and operands
//   alu_instruction/regA/regB    : operand registers driven to the ALU
//   alu_result, alu_flags        : ALU outputs, sampled at the end of EXEC
//   resp_valid/ready             : response handshake
//   resp_id/result/flags         : response contents
//   busy                         : high whenever not IDLE
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic [2:0]  resp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;
    logic        grant1;

    // Requester 1 wins when it is the only one asking, or on a tie when
    // requester 0 was the one served last.
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        flags_d      = flags_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!reset) begin
                    req0_ready = req0_valid && !grant1;
                    req1_ready = grant1;
                end
                if (req0_valid || req1_valid) begin
                    instr_d = grant1 ? req1_instr : req0_instr;
                    a_d     = grant1 ? req1_a     : req0_a;
                    b_d     = grant1 ? req1_b     : req0_b;
                    id_d    = grant1;
                    cnt_d   = LAT_LOAD;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // <= 1 also drains a zero count so EXEC can never stick.
                if (cnt_q <= 4'd1) begin
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    cnt_d    = '0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign alu_instruction = instr_q;
    assign alu_regA        = a_q;
    assign alu_regB        = b_q;
    assign resp_valid      = (state_q == RESP);
    assign resp_id         = id_q;
    assign resp_result     = result_q;
    assign resp_flags      = flags_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with ALU_LAT = 3 and a behavioural ALU.
module tb_alu_arbiter;

    localparam int unsigned LAT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_instr, req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_instr, req1_a, req1_b;
    logic [31:0] alu_instruction, alu_regA, alu_regB;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_result;
    logic [2:0]  resp_flags;
    logic        busy;

    int errors = 0;
    int checks = 0;
    bit last_served;   // requester that completed most recently (1 after reset)

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_instr(req0_instr), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_instr(req1_instr), .req1_a(req1_a), .req1_b(req1_b),
        .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: {flags, result}; AND for the 32'h00200024 opcode.
    function automatic logic [34:0] ref_alu(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        if (i == 32'h00200024) r = a & b;
        else if (i[0])         r = a + b;
        else                   r = a ^ b;
        return {(r == 32'd0), r[31], ^r, r};
    endfunction

    always_comb {alu_flags, alu_result} = ref_alu(alu_instruction, alu_regA, alu_regB);

    function automatic logic [31:0] rand_instr();
        return ($urandom_range(0, 3) == 0) ? 32'h00200024 : $urandom;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_ops();
        req0_instr = rand_instr(); req0_a = $urandom; req0_b = $urandom;
        req1_instr = rand_instr(); req1_a = $urandom; req1_b = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        last_served = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        rand_ops();
        step(); step();
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b exp 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b exp 0", req1_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({resp_id, resp_result, resp_flags} !== 36'd0) begin errors++; $display("FAIL reset_resp got %h exp 0", {resp_id, resp_result, resp_flags}); end
        checks++; if ({alu_instruction, alu_regA, alu_regB} !== 96'd0) begin errors++; $display("FAIL reset_operands got %h exp 0", {alu_instruction, alu_regA, alu_regB}); end
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        last_served = 1'b1;
        step();
    endtask

    // AND op on requester 0; req0_a is scrambled during EXEC to check operand hold.
    task automatic test_single_op();
        logic [34:0] exp;
        req0_valid = 1'b1; req0_instr = 32'h00200024; req0_a = 32'hFF; req0_b = 32'hA0;
        exp = ref_alu(32'h00200024, 32'hFF, 32'hA0);
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_grant got %b exp 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) begin
            req0_a = $urandom;
            #1;
            checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_exec_%0d got valid=%b busy=%b exp 0/1", k, resp_valid, busy); end
            checks++; if (alu_regA !== 32'hFF) begin errors++; $display("FAIL single_regA_hold got %h exp 000000ff", alu_regA); end
            step();
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b exp 1", resp_valid); end
        checks++; if (resp_result !== 32'hA0 || resp_id !== 1'b0) begin errors++; $display("FAIL single_result got %h id %b exp 000000a0 id 0", resp_result, resp_id); end
        checks++; if (resp_flags !== exp[34:32]) begin errors++; $display("FAIL single_flags got %b exp %b", resp_flags, exp[34:32]); end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        last_served = 1'b0;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got valid=%b busy=%b exp 0/0", resp_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic [34:0] exp;
        rand_ops();
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp = ref_alu(req1_instr, req1_a, req1_b);
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_tie_grant got %b exp 01", {req0_ready, req1_ready}); end
        step();
        req1_valid = 1'b0;
        repeat (LAT) step();
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d got valid=%b id=%b exp 1/1", i, resp_valid, resp_id); end
            checks++; if ({resp_flags, resp_result} !== exp) begin errors++; $display("FAIL bp_data_%0d got %h exp %h", i, {resp_flags, resp_result}, exp); end
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready_%0d got %b exp 00", i, {req0_ready, req1_ready}); end
            step();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b1 || {resp_flags, resp_result} !== exp) begin errors++; $display("FAIL bp_release got %b %h exp 1 %h", resp_valid, {resp_flags, resp_result}, exp); end
        step();
        resp_ready = 1'b0;
        last_served = 1'b1;
        checks++; if (resp_valid !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("FAIL bp_after got valid=%b ready0=%b exp 0/1", resp_valid, req0_ready); end
        req0_valid = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_single_resp got valid=%b busy=%b exp 0/0", resp_valid, busy); end
    endtask

    task automatic test_reset_mid_op();
        rand_ops();
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        repeat (LAT) step();
        resp_ready = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b0) begin errors++; $display("FAIL mid_pre_resp got valid=%b id=%b exp 1/0", resp_valid, resp_id); end
        step();
        resp_ready = 1'b0;
        last_served = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL mid_tie_grant got %b exp 01", {req0_ready, req1_ready}); end
        step();
        step();
        reset = 1'b1; resp_ready = 1'b1;
        step();
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready_in_reset got %b exp 00", {req0_ready, req1_ready}); end
        checks++; if ({resp_valid, busy, resp_id, resp_result, resp_flags} !== 38'd0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", {resp_valid, busy, resp_id, resp_result, resp_flags}); end
        checks++; if ({alu_instruction, alu_regA, alu_regB} !== 96'd0) begin errors++; $display("FAIL mid_reset_operands got %h exp 0", {alu_instruction, alu_regA, alu_regB}); end
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        last_served = 1'b1;
        for (int unsigned k = 0; k < LAT + 3; k++) begin
            step();
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp_%0d got %b exp 0", k, resp_valid); end
        end
        resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_next_tie got %b exp 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

    // Random valids, operands and backpressure against a transaction-level model:
    // at most one op outstanding, response visible LAT edges after accept.
    task automatic test_random();
        bit          have_op = 1'b0;
        bit          op_id = 1'b0;
        int          age = 0;
        int          nresp = 0;
        logic [34:0] op_exp = '0;
        bit          e0, e1;
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            resp_ready = $urandom_range(0, 1);
            #1;
            e0 = !have_op && req0_valid && (!req1_valid || last_served);
            e1 = !have_op && req1_valid && (!req0_valid || !last_served);
            checks++; if ({req0_ready, req1_ready} !== {e0, e1}) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, {req0_ready, req1_ready}, {e0, e1}); end
            checks++; if (resp_valid !== (have_op && age >= int'(LAT)) || busy !== have_op) begin errors++; $display("FAIL rand_status c%0d got valid=%b busy=%b exp %b/%b", c, resp_valid, busy, have_op && age >= int'(LAT), have_op); end
            if (have_op && age >= int'(LAT)) begin
                checks++; if (resp_id !== op_id || {resp_flags, resp_result} !== op_exp) begin errors++; $display("FAIL rand_resp c%0d got id=%b %h exp id=%b %h", c, resp_id, {resp_flags, resp_result}, op_id, op_exp); end
                if (resp_ready) begin have_op = 1'b0; last_served = op_id; nresp++; end
            end else if (e0 || e1) begin
                have_op = 1'b1; age = 0; op_id = e1;
                op_exp = e1 ? ref_alu(req1_instr, req1_a, req1_b) : ref_alu(req0_instr, req0_a, req0_b);
            end else if (have_op) begin
                age++;
            end
            if (have_op && age == 0 && (e0 || e1)) ; else if (have_op) ;
            step();
            if (have_op && !(age == 0 && (e0 || e1))) ;
        end
        checks++; if (nresp < 20) begin errors++; $display("FAIL rand_progress got %0d responses exp >= 20", nresp); end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    endtask

    task automatic test_fairness();
        logic [34:0] q_exp[$];
        bit          q_id[$];
        int          n_acc = 0, n_resp = 0, cyc = 0, prev = -1;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        while (n_resp < 6 && cyc < 200) begin
            rand_ops();
            #1;
            if (req0_ready || req1_ready) begin
                checks++; if (req1_ready !== n_acc[0] || req0_ready === req1_ready) begin errors++; $display("FAIL fair_order op%0d got %b exp id %0d", n_acc, {req0_ready, req1_ready}, n_acc[0]); end
                if (prev >= 0) begin
                    checks++; if (cyc - prev != int'(LAT) + 2) begin errors++; $display("FAIL fair_rate got gap %0d exp %0d", cyc - prev, LAT + 2); end
                end
                prev = cyc;
                q_id.push_back(req1_ready);
                q_exp.push_back(req1_ready ? ref_alu(req1_instr, req1_a, req1_b) : ref_alu(req0_instr, req0_a, req0_b));
                n_acc++;
            end
            if (resp_valid) begin
                if (q_id.size() == 0) begin
                    checks++; errors++; $display("FAIL fair_spurious got resp_valid=1 exp 0");
                end else begin
                    checks++; if (resp_id !== q_id[0] || {resp_flags, resp_result} !== q_exp[0]) begin errors++; $display("FAIL fair_resp%0d got id=%b %h exp id=%b %h", n_resp, resp_id, {resp_flags, resp_result}, q_id[0], q_exp[0]); end
                    void'(q_id.pop_front()); void'(q_exp.pop_front());
                end
                n_resp++;
            end
            step();
            cyc++;
        end
        checks++; if (n_resp != 6) begin errors++; $display("FAIL fair_count got %0d exp 6", n_resp); end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no completion exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        rand_ops();
        last_served = 1'b1;
        test_reset();
        test_single_op();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_fairness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
